pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer, synchronous flush with selectable payload-bit killing, and stall/bubble performance counters. It is the generic replacement for the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage RISC-V core. The producing stage drives the in_* side, and the consuming stage drives the out_* side. Hazard and branch logic drive flush.

---
 rtl/pipe_stage_buf.sv | 125 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush with payload-bit killing and perf counters.
module pipe_stage_buf #(
  parameter int                DATA_W    = 128,
  parameter logic [DATA_W-1:0] KILL_MASK = {DATA_W{1'b0}},
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              acc;
  logic              pop;

  assign acc       = in_valid & in_ready;
  assign pop       = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  if (SKID) begin : g_skid
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              m_free;

    // M can take a new occupant when it is empty or being popped this cycle.
    assign m_free   = ~m_valid | out_ready;
    assign in_ready = ~s_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (m_free) begin
        // acc and s_valid are mutually exclusive since in_ready = ~s_valid.
        m_valid <= s_valid | acc;
        s_valid <= 1'b0;
      end else if (acc) begin
        s_valid <= 1'b1;
      end
    end

    // NOTE: payload registers are reset because out_data must read 0 out of
    // reset; otherwise they only load on a write condition or a flush kill.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_data <= '0;
        s_data <= '0;
      end else if (flush) begin
        m_data <= m_data & ~KILL_MASK;
        s_data <= s_data & ~KILL_MASK;
      end else if (m_free) begin
        if (s_valid) begin
          m_data <= s_data;
        end else if (acc) begin
          m_data <= in_data;
        end
      end else if (acc) begin
        s_data <= in_data;
      end
    end
  end else begin : g_reg
    assign in_ready = ~m_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid <= 1'b0;
      end else if (flush) begin
        m_valid <= 1'b0;
      end else if (acc) begin
        m_valid <= 1'b1;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_data <= '0;
      end else if (flush) begin
        m_data <= m_data & ~KILL_MASK;
      end else if (acc) begin
        m_data <= in_data;
      end
    end
  end

  // Saturating perf counters; a clear on the same edge overrides the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!m_valid && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid streaming/backpressure/flush/reset,
// combinational-ready mode, and counter saturation on a narrow counter.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKID=1, low nibble killed on flush
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0, a_clr = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_stall, a_bubble;

  // Instance B: SKID=0
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0, b_clr = 1'b0;
  logic [31:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [15:0] b_stall, b_bubble;

  // Instance C: 4-bit counters, kept idle
  logic        c_in_valid = 1'b0, c_out_ready = 1'b0, c_flush = 1'b0, c_clr = 1'b0;
  logic [31:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [3:0]  c_stall, c_bubble;

  pipe_stage_buf #(.DATA_W(32), .KILL_MASK(32'h0000_000F), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .clr_cnt(a_clr), .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipe_stage_buf #(.DATA_W(32), .KILL_MASK(32'h0000_0000), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .clr_cnt(b_clr), .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  pipe_stage_buf #(.DATA_W(32), .KILL_MASK(32'h0000_0000), .SKID(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .flush(c_flush), .clr_cnt(c_clr), .stall_cnt(c_stall), .bubble_cnt(c_bubble));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backpressure schedule, one entry per cycle b1..b14 (index 0..13).
  // The producer holds beat 4 from b4 until it is accepted in b8.
  int unsigned bp_data [14] = '{1, 2, 3, 4, 4, 4, 4, 4, 5, 6, 7, 8, 0, 0};
  bit          bp_iv   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit          bp_or   [14] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  bit          bp_ov   [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int unsigned bp_od   [14] = '{0, 1, 2, 2, 2, 2, 2, 3, 4, 5, 6, 7, 8, 0};
  bit          bp_ir   [14] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data",  a_out_data,       32'd0);
    check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_a_stall",     32'(a_stall),     32'd0);
    check("rst_a_bubble",    32'(a_bubble),    32'd0);
    check("rst_b_in_ready",  32'(b_in_ready),  32'd1);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_c_bubble",    32'(c_bubble),    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- streaming 1..8 (cycle 1 = first edge after release) ----------------
    a_in_valid  = 1'b1;
    a_in_data   = 32'd1;
    a_out_ready = 1'b1;
    tick();
    for (int k = 2; k <= 9; k++) begin
      check("stream_out_valid", 32'(a_out_valid), 32'd1);
      check("stream_out_data",  a_out_data,       32'(k - 1));
      check("stream_in_ready",  32'(a_in_ready),  32'd1);
      if (k == 2) check("stream_bubble_c1", 32'(a_bubble), 32'd1);
      if (k <= 8) begin
        a_in_data = 32'(k);
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
    end
    check("stream_drained",    32'(a_out_valid), 32'd0);
    check("stream_bubble_end", 32'(a_bubble),    32'd1);
    check("stream_stall_end",  32'(a_stall),     32'd0);

    // ---------------- backpressure (counters cleared in b1) ----------------
    for (int i = 0; i < 14; i++) begin
      a_in_valid  = bp_iv[i];
      a_in_data   = bp_data[i];
      a_out_ready = bp_or[i];
      a_clr       = (i == 0);
      #1;
      check("bp_out_valid", 32'(a_out_valid), 32'(bp_ov[i]));
      check("bp_in_ready",  32'(a_in_ready),  32'(bp_ir[i]));
      if (bp_ov[i]) check("bp_out_data", a_out_data, bp_od[i]);
      tick();
    end
    a_clr = 1'b0;
    check("bp_stall_cnt",  32'(a_stall),     32'd4);
    check("bp_bubble_cnt", 32'(a_bubble),    32'd1);
    check("bp_empty",      32'(a_out_valid), 32'd0);

    // ---------------- flush with kill mask ----------------
    a_in_valid  = 1'b1;
    a_in_data   = 32'hABCD_1234;
    a_out_ready = 1'b0;
    tick();
    check("fl_m_loaded", a_out_data, 32'hABCD_1234);
    a_in_data = 32'h5555_5555;
    tick();
    check("fl_s_full_ready", 32'(a_in_ready), 32'd0);
    a_in_data = 32'd9;
    a_flush   = 1'b1;
    tick();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    check("fl_out_valid", 32'(a_out_valid), 32'd0);
    check("fl_in_ready",  32'(a_in_ready),  32'd1);
    check("fl_killed_m",  a_out_data,       32'hABCD_1230);
    tick();
    check("fl_no_beat9",  32'(a_out_valid), 32'd0);
    check("fl_data_hold", a_out_data,       32'hABCD_1230);
    // flush while a beat is accepted: the beat must be dropped
    a_in_valid = 1'b1;
    a_in_data  = 32'h77;
    a_flush    = 1'b1;
    tick();
    a_flush = 1'b0;
    check("fl_acc_dropped", 32'(a_out_valid), 32'd0);
    check("fl_acc_data",    a_out_data,       32'hABCD_1230);
    check("fl_acc_ready",   32'(a_in_ready),  32'd1);
    a_in_data = 32'h42;
    tick();
    check("fl_reaccept_valid", 32'(a_out_valid), 32'd1);
    check("fl_reaccept_data",  a_out_data,       32'h42);

    // ---------------- async reset mid-stream ----------------
    a_in_data   = 32'h11;
    a_out_ready = 1'b0;
    tick();
    check("mr_pre_data",  a_out_data,       32'h42);
    check("mr_pre_ready", 32'(a_in_ready),  32'd0);
    #2 rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(a_out_valid), 32'd0);
    check("mr_out_data",  a_out_data,       32'd0);
    check("mr_in_ready",  32'(a_in_ready),  32'd1);
    check("mr_stall",     32'(a_stall),     32'd0);
    check("mr_bubble",    32'(a_bubble),    32'd0);
    #1 rst = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h33;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("mr_first_valid", 32'(a_out_valid), 32'd1);
    check("mr_first_data",  a_out_data,       32'h33);
    tick();
    check("mr_drained", 32'(a_out_valid), 32'd0);

    // ---------------- SKID=0 combinational ready ----------------
    b_in_valid  = 1'b1;
    b_in_data   = 32'hA1;
    b_out_ready = 1'b0;
    #1;
    check("s0_empty_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_data   = 32'hA2;
    b_out_ready = 1'b1;
    #1;
    check("s0_ready_hi1", 32'(b_in_ready), 32'd1);
    check("s0_data_a1",   b_out_data,      32'hA1);
    tick();
    b_in_data   = 32'hA3;
    b_out_ready = 1'b0;
    #1;
    check("s0_ready_lo",  32'(b_in_ready),  32'd0);
    check("s0_valid_a2",  32'(b_out_valid), 32'd1);
    check("s0_data_a2",   b_out_data,       32'hA2);
    tick();
    b_out_ready = 1'b1;
    #1;
    check("s0_ready_hi2", 32'(b_in_ready), 32'd1);
    check("s0_data_hold", b_out_data,      32'hA2);
    tick();
    b_in_valid = 1'b0;
    #1;
    check("s0_valid_a3", 32'(b_out_valid), 32'd1);
    check("s0_data_a3",  b_out_data,       32'hA3);
    tick();
    check("s0_drained", 32'(b_out_valid), 32'd0);

    // ---------------- counter saturation, CNT_W=4 ----------------
    c_clr = 1'b1;
    tick();
    check("sat_cleared", 32'(c_bubble), 32'd0);
    c_clr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sat_bubble", 32'(c_bubble), (k < 15) ? 32'(k) : 32'd15);
    end
    check("sat_stall", 32'(c_stall), 32'd0);
    c_clr = 1'b1;
    tick();
    check("sat_clr_zero", 32'(c_bubble), 32'd0);
    c_clr = 1'b0;
    tick();
    check("sat_restart", 32'(c_bubble), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
